uart_tx_frame_engine: RTL and testbench

// - Transmit side of the APB UART, the companion to the RX path: buffers bytes written from the APB side and serialises them on UART_TXD.
// - Frame format: start bit, 5..8 data bits LSB-first, optional even parity, one or two stop bits.
// - Bit timing comes from the baud generator's 16x-oversample strobe. Raises TXdone and error_tx_detect for the APB interface.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/tx_fifo_sync.sv | 58 +++++
 rtl/uart_tx_frame_engine.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state type, frame limits and the
// data-length legality helper used by the TX and RX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } tx_state_t;

    localparam int unsigned UART_OSR      = 16;
    localparam int unsigned UART_MIN_BITS = 5;
    localparam int unsigned UART_MAX_BITS = 8;

    function automatic logic frame_len_legal(input logic [3:0] n);
        return (32'(n) >= UART_MIN_BITS) && (32'(n) <= UART_MAX_BITS);
    endfunction

endpackage

// File: rtl/tx_fifo_sync.sv
// Synchronous single-clock FIFO with occupancy count; shared by the UART TX
// and RX buffers. A pop frees a slot in the same cycle, so push+pop at full is accepted.
module tx_fifo_sync #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    full,
    output logic                    not_empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (level == (AW+1)'(DEPTH));
    assign not_empty = (level != '0);
    assign rd_data   = mem[rd_ptr];
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// APB UART transmit engine: buffers written bytes and serialises them as
// start / 5..8 data bits LSB-first / optional even parity / one or two stop bits.
module uart_tx_frame_engine
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OSR    = UART_OSR
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    tx_en,
    input  logic                    baud_tick,
    input  logic                    parity_bit_mode,
    input  logic                    stop_bit_twice,
    input  logic [3:0]              number_data_send,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    err_clr,
    output logic                    UART_TXD,
    output logic                    tx_fifo_full,
    output logic                    tx_not_empty,
    output logic [$clog2(DEPTH):0]  tx_level,
    output logic                    tx_busy,
    output logic                    TXdone,
    output logic                    error_tx_detect
);

    localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

    tx_state_t         state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              parity_acc;
    logic              cfg_parity;
    logic              cfg_two_stop;
    logic [3:0]        cfg_nbits;

    logic              pop;
    logic              period_end;
    logic              last_bit;
    logic              err_set;
    logic [DATA_W-1:0] fifo_head;

    tx_fifo_sync #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (wr_en),
        .wr_data   (wr_data),
        .pop       (pop),
        .rd_data   (fifo_head),
        .full      (tx_fifo_full),
        .not_empty (tx_not_empty),
        .level     (tx_level)
    );

    assign pop        = (state == IDLE) && tx_en && tx_not_empty;
    assign period_end = baud_tick && (tick_cnt == CNT_W'(OSR - 1));
    assign last_bit   = ({1'b0, bit_idx} == (cfg_nbits - 4'd1));
    assign tx_busy    = (state != IDLE);
    // A word pushed while full is only lost if the FSM is not popping that same cycle.
    assign err_set    = (wr_en && tx_fifo_full && !pop)
                      || (pop && !frame_len_legal(number_data_send));

    // UART_TXD is produced from the current state, so the line trails the FSM by one PCLK.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            parity_acc      <= 1'b0;
            cfg_parity      <= 1'b0;
            cfg_two_stop    <= 1'b0;
            cfg_nbits       <= 4'(UART_MAX_BITS);
            UART_TXD        <= 1'b1;
            TXdone          <= 1'b0;
            error_tx_detect <= 1'b0;
        end else begin
            TXdone <= 1'b0;

            if (err_set) begin
                error_tx_detect <= 1'b1;
            end else if (err_clr) begin
                error_tx_detect <= 1'b0;
            end

            if ((state != IDLE) && baud_tick) begin
                tick_cnt <= period_end ? '0 : tick_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    UART_TXD <= 1'b1;
                    if (pop) begin
                        shreg        <= fifo_head[7:0];
                        cfg_parity   <= parity_bit_mode;
                        cfg_two_stop <= stop_bit_twice;
                        cfg_nbits    <= frame_len_legal(number_data_send)
                                        ? number_data_send : 4'(UART_MAX_BITS);
                        parity_acc   <= 1'b0;
                        tick_cnt     <= '0;
                        bit_idx      <= '0;
                        state        <= START;
                    end
                end
                START: begin
                    UART_TXD <= 1'b0;
                    if (period_end) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    UART_TXD <= shreg[bit_idx];
                    if (period_end) begin
                        parity_acc <= parity_acc ^ shreg[bit_idx];
                        if (last_bit) begin
                            state <= cfg_parity ? PARITY : STOP1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    UART_TXD <= parity_acc;
                    if (period_end) begin
                        state <= STOP1;
                    end
                end
                STOP1: begin
                    UART_TXD <= 1'b1;
                    if (period_end) begin
                        if (cfg_two_stop) begin
                            state <= STOP2;
                        end else begin
                            state  <= IDLE;
                            TXdone <= 1'b1;
                        end
                    end
                end
                STOP2: begin
                    UART_TXD <= 1'b1;
                    if (period_end) begin
                        state  <= IDLE;
                        TXdone <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: directed frame table, FIFO and
// reset corner cases, and a randomized run checked by a line-level frame decoder.
module tb_uart_tx_frame_engine;

    localparam int DEPTH = 16;
    localparam int OSR   = 16;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       tx_en = 1'b0;
    logic       baud_tick = 1'b0;
    logic       parity_bit_mode = 1'b0;
    logic       stop_bit_twice = 1'b0;
    logic [3:0] number_data_send = 4'd8;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       err_clr = 1'b0;
    logic       UART_TXD;
    logic       tx_fifo_full;
    logic       tx_not_empty;
    logic [4:0] tx_level;
    logic       tx_busy;
    logic       TXdone;
    logic       error_tx_detect;

    uart_tx_frame_engine #(
        .DEPTH  (DEPTH),
        .DATA_W (8),
        .OSR    (OSR)
    ) dut (
        .PCLK             (PCLK),
        .PRESET           (PRESET),
        .tx_en            (tx_en),
        .baud_tick        (baud_tick),
        .parity_bit_mode  (parity_bit_mode),
        .stop_bit_twice   (stop_bit_twice),
        .number_data_send (number_data_send),
        .wr_en            (wr_en),
        .wr_data          (wr_data),
        .err_clr          (err_clr),
        .UART_TXD         (UART_TXD),
        .tx_fifo_full     (tx_fifo_full),
        .tx_not_empty     (tx_not_empty),
        .tx_level         (tx_level),
        .tx_busy          (tx_busy),
        .TXdone           (TXdone),
        .error_tx_detect  (error_tx_detect)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Baud strobe: every cycle when tick_div<=1, otherwise with probability 1/tick_div.
    int tick_div = 1;
    always @(negedge PCLK) begin
        if (tick_div <= 1) baud_tick = 1'b1;
        else baud_tick = ($urandom_range(tick_div - 1) == 0);
    end

    // Reference: expected line bits of one frame, as a '0'/'1' string in send order.
    function automatic string frame_bits(input logic [7:0] d, input int n, input bit par, input bit two);
        string s;
        int    m;
        int    p;
        s = "0";
        p = 0;
        m = (n < 5 || n > 8) ? 8 : n;
        for (int i = 0; i < m; i++) begin
            if (d[i]) s = {s, "1"};
            else s = {s, "0"};
            p ^= int'(d[i]);
        end
        if (par) begin
            if (p != 0) s = {s, "1"};
            else s = {s, "0"};
        end
        s = {s, "1"};
        if (two) s = {s, "1"};
        return s;
    endfunction

    // Model FIFO of accepted words plus a line decoder that counts baud ticks per bit.
    logic [7:0] mq[$];
    bit         in_frame = 0;
    string      fbits;
    int         c = 0;
    bit         bit_bad = 0;
    bit         mon_exp_done = 0;
    int         frames_done = 0;
    int         done_pulses = 0;
    longint     cyc = 0;
    longint     last_done_cyc = 0;
    int         gaps[$];
    logic       par_p = 0, two_p = 0, en_p = 0;
    logic [3:0] nds_p = 4'd8;

    always @(posedge PCLK) begin
        #1;
        cyc++;
        mon_exp_done = 0;
        if (PRESET) begin
            in_frame = 0;
            c = 0;
            bit_bad = 0;
        end else begin
            if (!in_frame && UART_TXD === 1'b0) begin
                if (mq.size() == 0) begin
                    check("start_without_data", 1, 0);
                end else begin
                    check("pop_needs_tx_en", en_p, 1);
                    fbits = frame_bits(mq.pop_front(), int'(nds_p), par_p, two_p);
                    in_frame = 1;
                    c = 0;
                    bit_bad = 0;
                    gaps.push_back(int'(cyc - last_done_cyc));
                end
            end
            if (in_frame) begin
                if (UART_TXD !== (fbits[c / OSR] == "1")) bit_bad = 1;
                if (baud_tick) begin
                    c++;
                    if (c % OSR == 0) begin
                        check($sformatf("frame%0d_bit%0d", frames_done, c / OSR - 1), !bit_bad, 1);
                        bit_bad = 0;
                    end
                    if (c == OSR * fbits.len()) begin
                        mon_exp_done = 1;
                        in_frame = 0;
                        frames_done++;
                        last_done_cyc = cyc;
                    end
                end
            end
        end
        if (TXdone === 1'b1) done_pulses++;
        check("txdone_timing", TXdone, mon_exp_done);
        par_p = parity_bit_mode;
        two_p = stop_bit_twice;
        en_p  = tx_en;
        nds_p = number_data_send;
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge PCLK);
        wr_en = 1'b1;
        wr_data = d;
        if (mq.size() < DEPTH) mq.push_back(d);
        @(negedge PCLK);
        wr_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(negedge PCLK);
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (mq.size() == 0 && !in_frame && !tx_busy) done = 1;
        end
        check("drain_within_budget", done, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       par;
        logic       two;
        string      frame;
        logic       err;
    } vec_t;

    vec_t tbl[6];

    task automatic set_row(input int r, input logic [7:0] d, input logic [3:0] n,
                           input logic p, input logic t, input string f, input logic e);
        tbl[r].data = d;
        tbl[r].nbits = n;
        tbl[r].par = p;
        tbl[r].two = t;
        tbl[r].frame = f;
        tbl[r].err = e;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        bit    found;
        bit    ok;
        string f;
        int    f0;
        int    d0;
        int    n_rand;

        set_row(0, 8'hA5, 4'd8,  1'b0, 1'b0, "0101001011",  1'b0);
        set_row(1, 8'h53, 4'd7,  1'b1, 1'b1, "01100101011", 1'b0);
        set_row(2, 8'h0D, 4'd5,  1'b1, 1'b0, "01011011",    1'b0);
        set_row(3, 8'h3C, 4'd4,  1'b0, 1'b0, "0001111001",  1'b1);
        set_row(4, 8'hFF, 4'd6,  1'b1, 1'b1, "0111111011",  1'b0);
        set_row(5, 8'h81, 4'd15, 1'b1, 1'b0, "01000000101", 1'b1);

        // Reset state
        repeat (3) step();
        check("rst_txd", UART_TXD, 1);
        check("rst_txdone", TXdone, 0);
        check("rst_err", error_tx_detect, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_level", tx_level, 0);
        check("rst_not_empty", tx_not_empty, 0);
        check("rst_full", tx_fifo_full, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Directed frame table, each row from an empty idle FIFO with tx_en=1
        for (int r = 0; r < 6; r++) begin
            @(negedge PCLK);
            parity_bit_mode = tbl[r].par;
            stop_bit_twice = tbl[r].two;
            number_data_send = tbl[r].nbits;
            tx_en = 1'b1;
            f = tbl[r].frame;
            push(tbl[r].data);
            lat = 0;
            found = 0;
            while (!found && lat < 20) begin
                step();
                lat++;
                if (UART_TXD === 1'b0) found = 1;
            end
            check($sformatf("row%0d_start_latency", r), lat, 2);
            if (found) begin
                for (int b = 0; b < f.len(); b++) begin
                    ok = 1;
                    for (int k = 0; k < OSR; k++) begin
                        if (!(b == 0 && k == 0)) step();
                        if (UART_TXD !== (f[b] == "1")) ok = 0;
                    end
                    check($sformatf("row%0d_bit%0d", r, b), ok, 1);
                end
                check($sformatf("row%0d_txdone", r), TXdone, 1);
            end
            step();
            check($sformatf("row%0d_err", r), error_tx_detect, tbl[r].err);
            if (tbl[r].err) begin
                pulse_err_clr();
                step();
                check($sformatf("row%0d_err_cleared", r), error_tx_detect, 0);
            end
        end

        // FIFO full, overflow drop, then simultaneous push/pop while full
        @(negedge PCLK);
        tx_en = 1'b0;
        parity_bit_mode = 1'b0;
        stop_bit_twice = 1'b0;
        number_data_send = 4'd8;
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
        step();
        check("full_level", tx_level, 16);
        check("full_flag", tx_fifo_full, 1);
        check("full_no_err_yet", error_tx_detect, 0);
        push(8'hEE);
        step();
        check("overflow_err", error_tx_detect, 1);
        check("overflow_level", tx_level, 16);
        pulse_err_clr();
        step();
        check("overflow_err_cleared", error_tx_detect, 0);
        @(negedge PCLK);
        tx_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h77;
        mq.push_back(8'h77);
        step();
        check("pushpop_full_level", tx_level, 16);
        check("pushpop_full_flag", tx_fifo_full, 1);
        @(negedge PCLK);
        wr_en = 1'b0;
        wait_idle(17 * 10 * OSR + 400);
        check("after_full_drain_level", tx_level, 0);

        // Back-to-back frames
        @(negedge PCLK);
        tx_en = 1'b0;
        push(8'hC3);
        push(8'h5A);
        push(8'h0F);
        step();
        check("b2b_level3", tx_level, 3);
        f0 = frames_done;
        d0 = done_pulses;
        gaps.delete();
        @(negedge PCLK);
        tx_en = 1'b1;
        step();
        check("b2b_level2", tx_level, 2);
        wait_idle(3 * 10 * OSR + 200);
        check("b2b_frames", frames_done - f0, 3);
        check("b2b_done_pulses", done_pulses - d0, 3);
        check("b2b_gap1", gaps[1], 2);
        check("b2b_gap2", gaps[2], 2);
        check("b2b_level0", tx_level, 0);

        // Reset during the data bits
        push(8'h96);
        push(8'h69);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (in_frame && c > 40) found = 1;
        end
        check("reached_data_bits", found, 1);
        check("pre_reset_level", tx_level, 1);
        @(negedge PCLK);
        PRESET = 1'b1;
        mq.delete();
        step();
        check("midrst_txd", UART_TXD, 1);
        check("midrst_level", tx_level, 0);
        check("midrst_busy", tx_busy, 0);
        check("midrst_txdone", TXdone, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        d0 = done_pulses;
        ok = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (UART_TXD !== 1'b1 || tx_busy !== 1'b0) ok = 0;
        end
        check("post_reset_idle", ok, 1);
        check("post_reset_no_txdone", done_pulses - d0, 0);

        // Randomized traffic, config changes and tx_en toggling with irregular ticks
        tick_div = 3;
        n_rand = 0;
        f0 = frames_done;
        for (int i = 0; i < 6000; i++) begin
            @(negedge PCLK);
            if ($urandom_range(19) == 0 && mq.size() < 12) begin
                wr_en = 1'b1;
                wr_data = 8'($urandom);
                mq.push_back(wr_data);
                n_rand++;
            end else begin
                wr_en = 1'b0;
            end
            if ($urandom_range(49) == 0) tx_en = ~tx_en;
            if ($urandom_range(29) == 0) begin
                parity_bit_mode = 1'($urandom);
                stop_bit_twice = 1'($urandom);
                number_data_send = 4'($urandom_range(8, 5));
            end
        end
        @(negedge PCLK);
        wr_en = 1'b0;
        tx_en = 1'b1;
        wait_idle(30000);
        check("rand_frames", frames_done - f0, n_rand);
        check("rand_no_err", error_tx_detect, 0);
        check("rand_level0", tx_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
